// File: rtl/ppg_fe_pkg.sv
// ---------------------------------------------------------------------------
// ppg_fe_pkg
// Shared types and constants for the PPG finger-clip frontend responder model.
//   channel_e      : which LED lights the photodiode (RED, IR or DARK)
//   state_e        : frontend sequencing states (SETTLE, CONVERT, WAIT)
//   *_W            : field widths of the frontend control and result buses
//   MID_SCALE      : ADC code that corresponds to zero photodiode signal
//   select_channel : decodes the two LED enables into a channel
// ---------------------------------------------------------------------------
package ppg_fe_pkg;

   typedef enum logic [1:0] {
      RED  = 2'd0,
      IR   = 2'd1,
      DARK = 2'd2
   } channel_e;

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      CONVERT = 2'd1,
      WAIT    = 2'd2
   } state_e;

   localparam int VPPG_W      = 8;
   localparam int DC_COMP_W   = 7;
   localparam int PGA_GAIN_W  = 4;
   localparam int LED_DRIVE_W = 4;

   localparam logic [VPPG_W-1:0] MID_SCALE = 8'd128;

   // Both LEDs on, or both off, leaves the photodiode effectively dark.
   function automatic channel_e select_channel(input logic led_red, input logic led_ir);
      channel_e ch;
      ch = DARK;
      if (led_red && !led_ir) begin
         ch = RED;
      end else if (led_ir && !led_red) begin
         ch = IR;
      end
      return ch;
   endfunction

endpackage

// File: rtl/ppg_frontend_model_if.sv
// ---------------------------------------------------------------------------
// ppg_frontend_model_if
// Bundle between the PPG controller and the frontend responder model.
//   LED_RED, LED_IR : LED enables               (controller -> frontend)
//   LED_Drive       : LED brightness code       (controller -> frontend)
//   DC_Comp         : DC offset compensation    (controller -> frontend)
//   PGA_Gain        : PGA gain code             (controller -> frontend)
//   Vppg            : last completed ADC result (frontend -> controller)
//   Vppg_Valid      : one-cycle strobe on update(frontend -> controller)
//   Settled         : frontend settled/converting (frontend -> controller)
//   Clip            : last result was clamped, only with PPG_FE_CLIP_FLAG_EN
// modport master = controller side, modport slave = frontend model side.
// ---------------------------------------------------------------------------
interface ppg_frontend_model_if;
   import ppg_fe_pkg::*;

   logic                   LED_RED;
   logic                   LED_IR;
   logic [LED_DRIVE_W-1:0] LED_Drive;
   logic [DC_COMP_W-1:0]   DC_Comp;
   logic [PGA_GAIN_W-1:0]  PGA_Gain;
   logic [VPPG_W-1:0]      Vppg;
   logic                   Vppg_Valid;
   logic                   Settled;
`ifdef PPG_FE_CLIP_FLAG_EN
   logic                   Clip;

   modport master (
      output LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain,
      input  Vppg, Vppg_Valid, Settled, Clip
   );

   modport slave (
      input  LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain,
      output Vppg, Vppg_Valid, Settled, Clip
   );
`else
   modport master (
      output LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain,
      input  Vppg, Vppg_Valid, Settled
   );

   modport slave (
      input  LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain,
      output Vppg, Vppg_Valid, Settled
   );
`endif

endinterface

// File: rtl/ppg_fe_triangle.sv
// ---------------------------------------------------------------------------
// ppg_fe_triangle
// Synthetic AC (pulsatile) component of the PPG signal: a 5-bit triangle that
// steps by one every TRI_DIV cycles, bouncing between 0 and 31. It starts at 0
// heading up and free-runs regardless of the frontend state.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   tri_val : current triangle value 0..31
// ---------------------------------------------------------------------------
module ppg_fe_triangle #(
   parameter int TRI_DIV = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [4:0] tri_val
);

   localparam logic [15:0] PRE_LAST = 16'(TRI_DIV - 1);

   logic [15:0] pre_q, pre_d;
   logic [4:0]  tri_q, tri_d;
   logic        up_q, up_d;

   // Prescaler wraps at TRI_DIV-1; on the wrap the triangle takes one step,
   // turning around when it sits at either end of its range.
   always_comb begin
      pre_d = pre_q + 16'd1;
      tri_d = tri_q;
      up_d  = up_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (up_q) begin
            if (tri_q == 5'd31) begin
               up_d  = 1'b0;
               tri_d = 5'd30;
            end else begin
               tri_d = tri_q + 5'd1;
            end
         end else begin
            if (tri_q == 5'd0) begin
               up_d  = 1'b1;
               tri_d = 5'd1;
            end else begin
               tri_d = tri_q - 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         tri_q <= '0;
         up_q  <= 1'b1;
      end else begin
         pre_q <= pre_d;
         tri_q <= tri_d;
         up_q  <= up_d;
      end
   end

   assign tri_val = tri_q;

endmodule

// File: rtl/ppg_frontend_model.sv
// ---------------------------------------------------------------------------
// ppg_frontend_model
// Cycle-accurate responder model of the finger-clip analog frontend plus its
// 8-bit ADC. It turns the controller's LED / DC compensation / PGA settings
// into a Vppg sample stream so the closed-loop DC/PGA search can be exercised
// in emulation as well as in simulation.
//   CLK   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   fe    : ppg_frontend_model_if.slave (settings in, Vppg/Vppg_Valid/Settled
//           and optionally Clip out)
// Optional feature macro: PPG_FE_CLIP_FLAG_EN adds the Clip flag register.
// ---------------------------------------------------------------------------
module ppg_frontend_model
   import ppg_fe_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int CONV_CYCLES   = 4,
   parameter int SAMPLE_DIV    = 32,
   parameter int TRI_DIV       = 64,
   parameter int BASE_RED      = 40,
   parameter int BASE_IR       = 48,
   parameter int COMP_STEP     = 8
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   ppg_frontend_model_if.slave  fe
);

   localparam logic [5:0]  BASE_RED_L  = 6'(BASE_RED);
   localparam logic [5:0]  BASE_IR_L   = 6'(BASE_IR);
   localparam logic [3:0]  COMP_STEP_L = 4'(COMP_STEP);
   localparam logic [15:0] SETTLE_RST  = 16'(SETTLE_CYCLES);
   // A detected change is seen one edge late, so the reload is one shorter to
   // keep the settle window exactly SETTLE_CYCLES edges after the change.
   localparam logic [15:0] SETTLE_LD   = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] CONV_LD     = 16'(CONV_CYCLES - 1);
   localparam logic [15:0] PER_LD      = 16'(SAMPLE_DIV - 1);

   logic [4:0] tri_val;

   ppg_fe_triangle #(
      .TRI_DIV (TRI_DIV)
   ) u_triangle (
      .clk     (CLK),
      .rst_n   (rst_n),
      .tri_val (tri_val)
   );

   channel_e               chan;
   logic [5:0]             base_sel;
   logic [4:0]             ac;
   logic [4:0]             drive_p1;
   logic [4:0]             gain_p1;
   logic [9:0]             light;
   logic [10:0]            comp_off;
   logic signed [12:0]     d_val;
   logic signed [17:0]     prod;
   logic signed [17:0]     p_val;
   logic signed [17:0]     sum;
   logic [VPPG_W-1:0]      vraw;

   state_e                 state_q, state_d;
   logic [15:0]            settle_cnt_q, settle_cnt_d;
   logic [15:0]            conv_cnt_q, conv_cnt_d;
   logic [15:0]            per_cnt_q, per_cnt_d;
   channel_e               chan_q, chan_d;
   logic [LED_DRIVE_W-1:0] drive_q, drive_d;
   logic [DC_COMP_W-1:0]   dc_q, dc_d;
   logic [PGA_GAIN_W-1:0]  gain_q, gain_d;
   logic [VPPG_W-1:0]      cap_q, cap_d;
   logic [VPPG_W-1:0]      vppg_q, vppg_d;
   logic                   valid_q, valid_d;
   logic                   change;
   logic                   start;
`ifdef PPG_FE_CLIP_FLAG_EN
   logic                   vraw_clip;
   logic                   cap_clip_q, cap_clip_d;
   logic                   clip_q, clip_d;
`endif

   // Analog chain: light level plus AC ripple minus DC compensation, through
   // the PGA (gain+1, /4 as an arithmetic shift so negatives floor), then
   // offset to mid-scale and clamped into the ADC's 0..255 range.
   always_comb begin
      chan     = select_channel(fe.LED_RED, fe.LED_IR);
      base_sel = '0;
      ac       = '0;
      case (chan)
         RED: begin
            base_sel = BASE_RED_L;
            ac       = {1'b0, tri_val[4:1]};
         end
         IR: begin
            base_sel = BASE_IR_L;
            ac       = tri_val;
         end
         default: begin
            base_sel = '0;
            ac       = '0;
         end
      endcase
      drive_p1 = {1'b0, fe.LED_Drive} + 5'd1;
      gain_p1  = {1'b0, fe.PGA_Gain} + 5'd1;
      light    = {4'd0, base_sel} * {5'd0, drive_p1};
      comp_off = {4'd0, fe.DC_Comp} * {7'd0, COMP_STEP_L};
      d_val    = $signed({3'd0, light}) + $signed({8'd0, ac}) - $signed({2'd0, comp_off});
      prod     = 18'(d_val) * $signed({13'd0, gain_p1});
      p_val    = prod >>> 2;
      sum      = p_val + $signed({10'd0, MID_SCALE});
      if (sum < 18'sd0) begin
         vraw = '0;
      end else if (sum > 18'sd255) begin
         vraw = '1;
      end else begin
         vraw = sum[7:0];
      end
   end

`ifdef PPG_FE_CLIP_FLAG_EN
   assign vraw_clip = (sum < 18'sd0) || (sum > 18'sd255);
`endif

   // Sequencer. A settings change overrides everything else: it forces
   // SETTLE, restarts the settle count and discards any conversion in
   // flight, including one that would have completed on this very edge.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      conv_cnt_d   = conv_cnt_q;
      per_cnt_d    = per_cnt_q;
      cap_d        = cap_q;
      vppg_d       = vppg_q;
      valid_d      = 1'b0;
      start        = 1'b0;
      chan_d       = chan;
      drive_d      = fe.LED_Drive;
      dc_d         = fe.DC_Comp;
      gain_d       = fe.PGA_Gain;
`ifdef PPG_FE_CLIP_FLAG_EN
      cap_clip_d   = cap_clip_q;
      clip_d       = clip_q;
`endif

      change = (chan != chan_q) || (fe.LED_Drive != drive_q) ||
               (fe.DC_Comp != dc_q) || (fe.PGA_Gain != gain_q);

      case (state_q)
         SETTLE: begin
            if (settle_cnt_q == '0) begin
               state_d = CONVERT;
               start   = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q - 16'd1;
            end
         end
         CONVERT: begin
            if (per_cnt_q != '0) begin
               per_cnt_d = per_cnt_q - 16'd1;
            end
            if (conv_cnt_q == '0) begin
               vppg_d  = cap_q;
               valid_d = 1'b1;
               state_d = WAIT;
`ifdef PPG_FE_CLIP_FLAG_EN
               clip_d  = cap_clip_q;
`endif
            end else begin
               conv_cnt_d = conv_cnt_q - 16'd1;
            end
         end
         WAIT: begin
            if (per_cnt_q == '0) begin
               state_d = CONVERT;
               start   = 1'b1;
            end else begin
               per_cnt_d = per_cnt_q - 16'd1;
            end
         end
         default: begin
            state_d      = SETTLE;
            settle_cnt_d = SETTLE_LD;
         end
      endcase

      if (start) begin
         cap_d      = vraw;
         conv_cnt_d = CONV_LD;
         per_cnt_d  = PER_LD;
`ifdef PPG_FE_CLIP_FLAG_EN
         cap_clip_d = vraw_clip;
`endif
      end

      if (change) begin
         state_d      = SETTLE;
         settle_cnt_d = SETTLE_LD;
         vppg_d       = vppg_q;
         valid_d      = 1'b0;
`ifdef PPG_FE_CLIP_FLAG_EN
         clip_d       = clip_q;
`endif
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SETTLE;
         settle_cnt_q <= SETTLE_RST;
         conv_cnt_q   <= '0;
         per_cnt_q    <= '0;
         chan_q       <= RED;
         drive_q      <= '0;
         dc_q         <= '0;
         gain_q       <= '0;
         cap_q        <= '0;
         vppg_q       <= '0;
         valid_q      <= 1'b0;
`ifdef PPG_FE_CLIP_FLAG_EN
         cap_clip_q   <= 1'b0;
         clip_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         conv_cnt_q   <= conv_cnt_d;
         per_cnt_q    <= per_cnt_d;
         chan_q       <= chan_d;
         drive_q      <= drive_d;
         dc_q         <= dc_d;
         gain_q       <= gain_d;
         cap_q        <= cap_d;
         vppg_q       <= vppg_d;
         valid_q      <= valid_d;
`ifdef PPG_FE_CLIP_FLAG_EN
         cap_clip_q   <= cap_clip_d;
         clip_q       <= clip_d;
`endif
      end
   end

   assign fe.Vppg       = vppg_q;
   assign fe.Vppg_Valid = valid_q;
   assign fe.Settled    = (state_q != SETTLE);
`ifdef PPG_FE_CLIP_FLAG_EN
   assign fe.Clip       = clip_q;
`endif

endmodule

// File: tb/tb_ppg_frontend_model.sv
// ---------------------------------------------------------------------------
// tb_ppg_frontend_model
// Self-checking bench for ppg_frontend_model. An edge-indexed reference of the
// frontend timing predicts each conversion start; the expected sample is
// pushed to a scoreboard queue and popped when Vppg_Valid is observed.
// A table of setting vectors is stepped through, followed by hand-written
// abort, completion-edge, repeated-change and mid-WAIT reset sequences.
// Honours PPG_FE_CLIP_FLAG_EN for the Clip checks.
// ---------------------------------------------------------------------------
module tb_ppg_frontend_model;
   import ppg_fe_pkg::*;

   localparam int SETTLE = 16;
   localparam int CONV   = 4;
   localparam int SDIV   = 32;
   localparam int TDIV   = 64;

   typedef struct {
      logic       red;
      logic       ir;
      logic [3:0] drive;
      logic [6:0] dc;
      logic [3:0] gain;
      int         lo;
      int         hi;
      logic       clip;
   } vec_t;

   typedef struct {
      int         due;
      logic [7:0] vppg;
      logic       clip;
   } exp_t;

   logic CLK;
   logic rst_n;

   ppg_frontend_model_if fe_if();

   ppg_frontend_model #(
      .SETTLE_CYCLES (SETTLE),
      .CONV_CYCLES   (CONV),
      .SAMPLE_DIV    (SDIV),
      .TRI_DIV       (TDIV),
      .BASE_RED      (40),
      .BASE_IR       (48),
      .COMP_STEP     (8)
   ) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .fe    (fe_if)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          edge_idx = -1;
   int          next_start = SETTLE;
   bit          model_settled = 1'b0;
   bit          have_prev = 1'b0;
   logic [16:0] prev_key = '0;
   exp_t        sb_q[$];
   int          strobe_count = 0;
   int          last_strobe_edge = -1;
   logic [7:0]  last_vppg = '0;
   logic        last_clip = 1'b0;
   vec_t        vecs[7];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic int tri_at(input int e);
      int s;
      s = (e / TDIV) % 62;
      return (s <= 31) ? s : 62 - s;
   endfunction

   function automatic logic [16:0] input_key();
      logic [1:0] ch;
      if (fe_if.LED_RED && !fe_if.LED_IR) ch = 2'd0;
      else if (fe_if.LED_IR && !fe_if.LED_RED) ch = 2'd1;
      else ch = 2'd2;
      return {ch, fe_if.LED_Drive, fe_if.DC_Comp, fe_if.PGA_Gain};
   endfunction

   task automatic exp_calc(input logic red, input logic ir, input int drive, input int dc,
                           input int gain, input int tv, output logic [7:0] v, output logic c);
      int l, ac, d, p, r;
      l  = 0;
      ac = 0;
      if (red && !ir) begin
         l  = 40 * (drive + 1);
         ac = tv / 2;
      end else if (ir && !red) begin
         l  = 48 * (drive + 1);
         ac = tv;
      end
      d = l + ac - dc * 8;
      p = (d * (gain + 1)) >>> 2;
      r = 128 + p;
      c = 1'b0;
      if (r < 0) begin
         r = 0;
         c = 1'b1;
      end else if (r > 255) begin
         r = 255;
         c = 1'b1;
      end
      v = 8'(r);
   endtask

   // Reference timing, evaluated at each rising edge with the inputs as the
   // DUT sees them on that edge.
   initial begin
      logic [16:0] cur;
      exp_t        item;
      forever begin
         @(posedge CLK);
         if (!rst_n) begin
            edge_idx      = -1;
            next_start    = SETTLE;
            model_settled = 1'b0;
            have_prev     = 1'b0;
            sb_q.delete();
         end else begin
            edge_idx++;
            cur = input_key();
            if (have_prev && cur != prev_key) begin
               next_start    = edge_idx + SETTLE;
               model_settled = 1'b0;
               sb_q.delete();
            end else if (edge_idx == next_start) begin
               item.due = edge_idx + CONV;
               exp_calc(fe_if.LED_RED, fe_if.LED_IR, int'(fe_if.LED_Drive), int'(fe_if.DC_Comp),
                        int'(fe_if.PGA_Gain), tri_at(edge_idx), item.vppg, item.clip);
               sb_q.push_back(item);
               next_start    = edge_idx + SDIV;
               model_settled = 1'b1;
            end
            prev_key  = cur;
            have_prev = 1'b1;
         end
      end
   end

   // Output monitor on the falling edge.
   initial begin
      exp_t item;
      forever begin
         @(negedge CLK);
         if (!rst_n) begin
            last_vppg = '0;
            last_clip = 1'b0;
         end else if (edge_idx >= 0) begin
            check_output("settled", int'(fe_if.Settled), int'(model_settled));
            if (fe_if.Vppg_Valid) begin
               strobe_count++;
               last_strobe_edge = edge_idx;
               if (sb_q.size() == 0) begin
                  check_output("unexpected_strobe_edge", edge_idx, -1);
               end else begin
                  item = sb_q.pop_front();
                  check_output("strobe_edge", edge_idx, item.due);
                  check_output("vppg", int'(fe_if.Vppg), int'(item.vppg));
`ifdef PPG_FE_CLIP_FLAG_EN
                  check_output("clip", int'(fe_if.Clip), int'(item.clip));
`endif
               end
               last_vppg = fe_if.Vppg;
`ifdef PPG_FE_CLIP_FLAG_EN
               last_clip = fe_if.Clip;
`endif
            end else begin
               check_output("vppg_hold", int'(fe_if.Vppg), int'(last_vppg));
`ifdef PPG_FE_CLIP_FLAG_EN
               check_output("clip_hold", int'(fe_if.Clip), int'(last_clip));
`endif
               if (sb_q.size() > 0 && sb_q[0].due <= edge_idx) begin
                  item = sb_q.pop_front();
                  check_output("missed_strobe_valid", 0, 1);
               end
            end
         end
      end
   end

   task automatic apply_stimulus(input vec_t v);
      @(posedge CLK);
      #1;
      fe_if.LED_RED   = v.red;
      fe_if.LED_IR    = v.ir;
      fe_if.LED_Drive = v.drive;
      fe_if.DC_Comp   = v.dc;
      fe_if.PGA_Gain  = v.gain;
   endtask

   task automatic wait_strobes(input int n, input string tag);
      int target;
      target = strobe_count + n;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         #1;
         if (strobe_count >= target) return;
      end
      check_output({tag, "_timeout_strobes"}, strobe_count, target);
   endtask

   initial begin
      int chg;
      int held;

      vecs[0] = '{1'b0, 1'b1, 4'd3, 7'd24,  4'd0,  128, 135, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 4'd3, 7'd0,   4'd15, 255, 255, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 4'd0, 7'd127, 4'd15, 0,   0,   1'b1};
      vecs[3] = '{1'b1, 1'b1, 4'd5, 7'd0,   4'd3,  128, 128, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 4'd2, 7'd15,  4'd1,  128, 135, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 4'd0, 7'd6,   4'd2,  122, 133, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 4'd0, 7'd1,   4'd0,  126, 126, 1'b0};

      rst_n           = 1'b0;
      fe_if.LED_RED   = vecs[0].red;
      fe_if.LED_IR    = vecs[0].ir;
      fe_if.LED_Drive = vecs[0].drive;
      fe_if.DC_Comp   = vecs[0].dc;
      fe_if.PGA_Gain  = vecs[0].gain;

      #12;
      check_output("reset_vppg", int'(fe_if.Vppg), 0);
      check_output("reset_valid", int'(fe_if.Vppg_Valid), 0);
      check_output("reset_settled", int'(fe_if.Settled), 0);
`ifdef PPG_FE_CLIP_FLAG_EN
      check_output("reset_clip", int'(fe_if.Clip), 0);
`endif
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #1;
      rst_n = 1'b1;

      wait_strobes(1, "first");
      check_output("first_strobe_edge", last_strobe_edge, SETTLE + CONV);
      wait_strobes(1, "second");
      check_output("second_strobe_edge", last_strobe_edge, SETTLE + CONV + SDIV);

      for (int i = 0; i < 7; i++) begin
         if (i > 0) apply_stimulus(vecs[i]);
         wait_strobes(2, $sformatf("vec%0d", i));
         check_range($sformatf("vec%0d_vppg_range", i), int'(last_vppg), vecs[i].lo, vecs[i].hi);
`ifdef PPG_FE_CLIP_FLAG_EN
         check_output($sformatf("vec%0d_clip", i), int'(last_clip), int'(vecs[i].clip));
`endif
      end

      // Abort two cycles into a conversion.
      wait_strobes(1, "pre_abort");
      held = int'(last_vppg);
      repeat (29) @(posedge CLK);
      #1;
      fe_if.DC_Comp = fe_if.DC_Comp ^ 7'd1;
      chg = edge_idx + 1;
      repeat (6) @(negedge CLK);
      #1;
      check_output("abort_vppg_hold", int'(fe_if.Vppg), held);
      check_output("abort_settled_low", int'(fe_if.Settled), 0);
      wait_strobes(1, "abort_recover");
      check_output("abort_recovery_delay", last_strobe_edge - chg, SETTLE + CONV);

      // Change lands on the edge that would complete a conversion.
      wait_strobes(1, "pre_complete");
      repeat (31) @(posedge CLK);
      #1;
      fe_if.DC_Comp = fe_if.DC_Comp ^ 7'd1;
      chg = edge_idx + 1;
      wait_strobes(1, "complete_recover");
      check_output("complete_edge_recovery_delay", last_strobe_edge - chg, SETTLE + CONV);

      // Repeated changes restart the settle window.
      wait_strobes(1, "pre_repeat");
      repeat (10) @(posedge CLK);
      #1;
      fe_if.PGA_Gain = 4'd5;
      repeat (5) @(posedge CLK);
      #1;
      fe_if.PGA_Gain = 4'd9;
      repeat (5) @(posedge CLK);
      #1;
      fe_if.PGA_Gain = 4'd2;
      chg = edge_idx + 1;
      wait_strobes(1, "repeat_recover");
      check_output("repeat_recovery_delay", last_strobe_edge - chg, SETTLE + CONV);

      // Reset pulse in the middle of WAIT.
      wait_strobes(1, "pre_reset");
      repeat (5) @(posedge CLK);
      #2;
      check_output("pre_reset_settled", int'(fe_if.Settled), 1);
      rst_n = 1'b0;
      #1;
      check_output("midreset_vppg", int'(fe_if.Vppg), 0);
      check_output("midreset_settled", int'(fe_if.Settled), 0);
      check_output("midreset_valid", int'(fe_if.Vppg_Valid), 0);
`ifdef PPG_FE_CLIP_FLAG_EN
      check_output("midreset_clip", int'(fe_if.Clip), 0);
`endif
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      rst_n = 1'b1;
      wait_strobes(1, "post_reset_first");
      check_output("post_reset_first_edge", last_strobe_edge, SETTLE + CONV);
      wait_strobes(1, "post_reset_second");
      check_output("post_reset_second_edge", last_strobe_edge, SETTLE + CONV + SDIV);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
